// File: rtl/execute_divide_iter.sv
// Purpose : iterative restoring divider for DIV / IDIV / AAM at 8/16/32-bit operand size.
// Latency : DONE on cycle N+2 after start (N/2+2 with DIV_RADIX4_EN), next cycle on a #DE precheck.
// Backpr. : div_busy stays high until the single DONE cycle; the execute stage stalls on it.
//
// Ports   : clk, rst_n (sync, active-low), exe_reset (flush), exe_cmd, operand size flags,
//           src (divisor), eax/edx (dividend low/high) -> div_busy, div_quotient,
//           div_remainder, exe_div_exception (all results valid in the DONE cycle).
// Option  : define DIV_RADIX4_EN to retire two quotient bits per DIVIDE cycle.

`ifndef CMD_DIV
`define CMD_DIV  7'd40
`endif
`ifndef CMD_IDIV
`define CMD_IDIV 7'd41
`endif
`ifndef CMD_AAM
`define CMD_AAM  7'd42
`endif

module execute_divide_iter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exe_reset,
   input  logic [6:0]  exe_cmd,
   input  logic        exe_is_8bit,
   input  logic        exe_operand_16bit,
   input  logic        exe_operand_32bit,
   input  logic [31:0] src,
   input  logic [31:0] eax,
   input  logic [31:0] edx,
   output logic        div_busy,
   output logic [31:0] div_quotient,
   output logic [31:0] div_remainder,
   output logic        exe_div_exception
);

   typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

   localparam logic [1:0] SZ8  = 2'd0;
   localparam logic [1:0] SZ16 = 2'd1;
   localparam logic [1:0] SZ32 = 2'd2;

`ifdef DIV_RADIX4_EN
   localparam logic [5:0] STEP = 6'd2;
`else
   localparam logic [5:0] STEP = 6'd1;
`endif

   state_t      state, state_nxt;

   // operand decode (IDLE)
   logic        is_aam, is_idiv, start;
   logic [1:0]  size_in;
   logic [63:0] dvd_raw, dvd_mag;
   logic [31:0] dvs_raw, dvs_mag, hi_in, lo_in;
   logic        sgn_a_in, sgn_b_in, pre_exc;

   // iteration state
   logic [31:0] rem_q, lo_q, quo_q, dvs_q;
   logic [5:0]  cnt_q;
   logic [1:0]  size_q;
   logic        idiv_q, sgn_a_q, sgn_b_q;
   logic [31:0] rem_nxt, lo_nxt, quo_nxt;

   // sign / range fixup
   logic [31:0] mask, half, q_mag, r_mag, q_fix, r_fix;
   logic        q_neg, range_exc;

   // One restoring step: shift the next dividend bit into the partial remainder and
   // subtract the divisor when it fits. Returns {quotient_bit, new_remainder}.
   // The remainder stays below the divisor, so 32 bits hold it between steps.
   function automatic logic [32:0] rstep(input logic [31:0] r, input logic in_bit,
                                         input logic [31:0] d);
      logic [32:0] sh;
      logic        qb;
      sh    = {r, in_bit};
      qb    = (sh >= {1'b0, d});
      rstep = {qb, qb ? (sh[31:0] - d) : sh[31:0]};
   endfunction

   // ---------------- operand decode ----------------
   always_comb begin
      is_aam  = (exe_cmd == `CMD_AAM);
      is_idiv = (exe_cmd == `CMD_IDIV);
      start   = is_aam | is_idiv | (exe_cmd == `CMD_DIV);

      if (is_aam) begin
         size_in  = SZ8;
         dvd_raw  = {56'd0, eax[7:0]};
         dvs_raw  = {24'd0, src[7:0]};
         sgn_a_in = 1'b0;
         sgn_b_in = 1'b0;
      end else if (exe_is_8bit) begin
         size_in  = SZ8;
         dvd_raw  = is_idiv ? {{48{eax[15]}}, eax[15:0]} : {48'd0, eax[15:0]};
         dvs_raw  = is_idiv ? {{24{src[7]}}, src[7:0]}   : {24'd0, src[7:0]};
         sgn_a_in = is_idiv & eax[15];
         sgn_b_in = is_idiv & src[7];
      end else if (exe_operand_32bit && !exe_operand_16bit) begin
         size_in  = SZ32;
         dvd_raw  = {edx, eax};
         dvs_raw  = src;
         sgn_a_in = is_idiv & edx[31];
         sgn_b_in = is_idiv & src[31];
      end else begin
         size_in  = SZ16;
         dvd_raw  = is_idiv ? {{32{edx[15]}}, edx[15:0], eax[15:0]}
                            : {32'd0, edx[15:0], eax[15:0]};
         dvs_raw  = is_idiv ? {{16{src[15]}}, src[15:0]} : {16'd0, src[15:0]};
         sgn_a_in = is_idiv & edx[15];
         sgn_b_in = is_idiv & src[15];
      end

      dvd_mag = sgn_a_in ? (64'd0 - dvd_raw) : dvd_raw;
      dvs_mag = sgn_b_in ? (32'd0 - dvs_raw) : dvs_raw;

      // Low half is left-aligned so the next dividend bit is always lo_q[31].
      case (size_in)
         SZ8: begin
            hi_in = {24'd0, dvd_mag[15:8]};
            lo_in = {dvd_mag[7:0], 24'd0};
         end
         SZ16: begin
            hi_in = {16'd0, dvd_mag[31:16]};
            lo_in = {dvd_mag[15:0], 16'd0};
         end
         default: begin
            hi_in = dvd_mag[63:32];
            lo_in = dvd_mag[31:0];
         end
      endcase

      // High half >= divisor means the quotient cannot fit in N bits; for IDIV this
      // is only the magnitude precheck, the exact signed limit is checked in FIXUP.
      pre_exc = (dvs_mag == 32'd0) | (hi_in >= dvs_mag);
   end

   // ---------------- iteration datapath ----------------
   always_comb begin
      logic [32:0] s1;
`ifdef DIV_RADIX4_EN
      logic [32:0] s2;
      s1      = rstep(rem_q, lo_q[31], dvs_q);
      s2      = rstep(s1[31:0], lo_q[30], dvs_q);
      rem_nxt = s2[31:0];
      lo_nxt  = {lo_q[29:0], 2'b00};
      quo_nxt = {quo_q[29:0], s1[32], s2[32]};
`else
      s1      = rstep(rem_q, lo_q[31], dvs_q);
      rem_nxt = s1[31:0];
      lo_nxt  = {lo_q[30:0], 1'b0};
      quo_nxt = {quo_q[30:0], s1[32]};
`endif
   end

   // ---------------- sign fixup and signed range check ----------------
   always_comb begin
      case (size_q)
         SZ8:     begin mask = 32'h0000_00FF; half = 32'h0000_0080; end
         SZ16:    begin mask = 32'h0000_FFFF; half = 32'h0000_8000; end
         default: begin mask = 32'hFFFF_FFFF; half = 32'h8000_0000; end
      endcase
      q_mag     = quo_q & mask;
      r_mag     = rem_q & mask;
      q_neg     = idiv_q & (sgn_a_q ^ sgn_b_q);
      q_fix     = (q_neg ? (32'd0 - q_mag) : q_mag) & mask;
      r_fix     = ((idiv_q & sgn_a_q) ? (32'd0 - r_mag) : r_mag) & mask;
      range_exc = idiv_q & (q_neg ? (q_mag > half) : (q_mag >= half));
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = pre_exc ? DONE : DIVIDE;
         DIVIDE:  if (cnt_q == STEP) state_nxt = FIXUP;
         FIXUP:   state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (exe_reset) state_nxt = IDLE;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      div_busy = (state != DONE);
   end

   // ---------------- datapath / result registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q             <= 32'd0;
         lo_q              <= 32'd0;
         quo_q             <= 32'd0;
         dvs_q             <= 32'd0;
         cnt_q             <= 6'd0;
         size_q            <= SZ8;
         idiv_q            <= 1'b0;
         sgn_a_q           <= 1'b0;
         sgn_b_q           <= 1'b0;
         div_quotient      <= 32'd0;
         div_remainder     <= 32'd0;
         exe_div_exception <= 1'b0;
      end else if (exe_reset) begin
         exe_div_exception <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               rem_q             <= hi_in;
               lo_q              <= lo_in;
               quo_q             <= 32'd0;
               dvs_q             <= dvs_mag;
               size_q            <= size_in;
               idiv_q            <= is_idiv;
               sgn_a_q           <= sgn_a_in;
               sgn_b_q           <= sgn_b_in;
               cnt_q             <= (size_in == SZ8) ? 6'd8 : (size_in == SZ16) ? 6'd16 : 6'd32;
               exe_div_exception <= pre_exc;
            end
            DIVIDE: begin
               rem_q <= rem_nxt;
               lo_q  <= lo_nxt;
               quo_q <= quo_nxt;
               cnt_q <= cnt_q - STEP;
            end
            FIXUP: begin
               div_quotient      <= q_fix;
               div_remainder     <= r_fix;
               exe_div_exception <= range_exc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_divide_iter.sv
`ifndef CMD_DIV
`define CMD_DIV  7'd40
`endif
`ifndef CMD_IDIV
`define CMD_IDIV 7'd41
`endif
`ifndef CMD_AAM
`define CMD_AAM  7'd42
`endif

module tb_execute_divide_iter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exe_reset;
   logic [6:0]  exe_cmd;
   logic        exe_is_8bit;
   logic        exe_operand_16bit;
   logic        exe_operand_32bit;
   logic [31:0] src, eax, edx;
   logic        div_busy;
   logic [31:0] div_quotient, div_remainder;
   logic        exe_div_exception;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] NOP = 7'd0;

   execute_divide_iter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .exe_reset         (exe_reset),
      .exe_cmd           (exe_cmd),
      .exe_is_8bit       (exe_is_8bit),
      .exe_operand_16bit (exe_operand_16bit),
      .exe_operand_32bit (exe_operand_32bit),
      .src               (src),
      .eax               (eax),
      .edx               (edx),
      .div_busy          (div_busy),
      .div_quotient      (div_quotient),
      .div_remainder     (div_remainder),
      .exe_div_exception (exe_div_exception)
   );

   always #5 clk = ~clk;

   function automatic int lat(input int n);
`ifdef DIV_RADIX4_EN
      return n / 2 + 2;
`else
      return n + 2;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one command; the sample point right after this is the start cycle.
   task automatic issue(input logic [6:0] cmd, input int n, input logic [31:0] s,
                        input logic [31:0] a, input logic [31:0] d);
      exe_cmd           = cmd;
      exe_is_8bit       = (n == 8);
      exe_operand_16bit = (n == 16);
      exe_operand_32bit = (n == 32);
      src               = s;
      eax               = a;
      edx               = d;
   endtask

   // Count edges from the start cycle until busy drops, bounded.
   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (div_busy && n < 80);
      check(tag, n, exp_lat);
   endtask

   initial begin
      int done_seen;
      rst_n = 1'b0;
      exe_reset = 1'b0;
      issue(NOP, 16, 32'd0, 32'd0, 32'd0);
      tick();
      tick();
      check("reset_busy", {31'd0, div_busy}, 32'd1);
      check("reset_quo",  div_quotient, 32'd0);
      check("reset_rem",  div_remainder, 32'd0);
      check("reset_exc",  {31'd0, exe_div_exception}, 32'd0);
      rst_n = 1'b1;
      tick();

      // DIV 8-bit 100/7
      issue(`CMD_DIV, 8, 32'h07, 32'h0064, 32'h0);
      wait_done("div8_lat", lat(8));
      exe_cmd = NOP;
      check("div8_quo", div_quotient, 32'h0E);
      check("div8_rem", div_remainder, 32'h02);
      check("div8_exc", {31'd0, exe_div_exception}, 32'd0);
      tick();
      check("div8_done_1cyc", {31'd0, div_busy}, 32'd1);
      check("div8_hold", div_quotient, 32'h0E);

      // IDIV 16-bit -100/7
      issue(`CMD_IDIV, 16, 32'h0007, 32'h0000_FF9C, 32'h0000_FFFF);
      wait_done("idiv16_lat", lat(16));
      exe_cmd = NOP;
      check("idiv16_quo", div_quotient, 32'h0000_FFF2);
      check("idiv16_rem", div_remainder, 32'h0000_FFFE);
      check("idiv16_exc", {31'd0, exe_div_exception}, 32'd0);
      tick();

      // DIV 32-bit divide by zero
      issue(`CMD_DIV, 32, 32'h0, 32'h1234, 32'h0);
      wait_done("div0_lat", 1);
      exe_cmd = NOP;
      check("div0_exc", {31'd0, exe_div_exception}, 32'd1);
      tick();

      // DIV 32-bit early overflow (high half == divisor)
      issue(`CMD_DIV, 32, 32'h5, 32'h0, 32'h5);
      wait_done("ovf_lat", 1);
      exe_cmd = NOP;
      check("ovf_exc", {31'd0, exe_div_exception}, 32'd1);
      tick();
      check("exc_held_idle", {31'd0, exe_div_exception}, 32'd1);

      // exe_reset clears a held exception
      exe_reset = 1'b1;
      tick();
      exe_reset = 1'b0;
      check("flush_clr_exc", {31'd0, exe_div_exception}, 32'd0);

      // IDIV 8-bit: +128/1 overflows, -128/1 fits
      issue(`CMD_IDIV, 8, 32'h01, 32'h0080, 32'h0);
      wait_done("idiv8p_lat", lat(8));
      exe_cmd = NOP;
      check("idiv8p_exc", {31'd0, exe_div_exception}, 32'd1);
      tick();
      issue(`CMD_IDIV, 8, 32'h01, 32'hFF80, 32'h0);
      wait_done("idiv8n_lat", lat(8));
      exe_cmd = NOP;
      check("idiv8n_quo", div_quotient, 32'h80);
      check("idiv8n_rem", div_remainder, 32'h0);
      check("idiv8n_exc", {31'd0, exe_div_exception}, 32'd0);
      tick();

      // AAM 79/10, size flags set to 32-bit to show AAM forces 8-bit
      issue(`CMD_AAM, 32, 32'h0A, 32'h0000_004F, 32'hFFFF_FFFF);
      wait_done("aam_lat", lat(8));
      exe_cmd = NOP;
      check("aam_quo", div_quotient, 32'h07);
      check("aam_rem", div_remainder, 32'h09);
      tick();

      // DIV 32-bit 2^32 / 3
      issue(`CMD_DIV, 32, 32'h3, 32'h0, 32'h1);
      wait_done("div32_lat", lat(32));
      exe_cmd = NOP;
      check("div32_quo", div_quotient, 32'h5555_5555);
      check("div32_rem", div_remainder, 32'h1);
      tick();

      // Flush at iteration 5 with the command still present
      issue(`CMD_DIV, 32, 32'h7, 32'hDEAD_BEEF, 32'h2);
      for (int i = 0; i < 5; i++) tick();
      exe_reset = 1'b1;
      tick();
      exe_reset = 1'b0;
      exe_cmd = NOP;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (!div_busy) done_seen++;
         tick();
      end
      check("flush_no_done", done_seen, 0);
      check("flush_quo_kept", div_quotient, 32'h5555_5555);
      check("flush_rem_kept", div_remainder, 32'h1);

      // Fresh DIV after the flush
      issue(`CMD_DIV, 32, 32'h10, 32'hFFFF_FFFF, 32'h0);
      wait_done("post_flush_lat", lat(32));
      exe_cmd = NOP;
      check("post_flush_quo", div_quotient, 32'h0FFF_FFFF);
      check("post_flush_rem", div_remainder, 32'hF);
      tick();

      // Command held through DONE restarts on the following cycle
      issue(`CMD_DIV, 8, 32'h09, 32'h0064, 32'h0);
      wait_done("restart_lat1", lat(8));
      tick();
      check("restart_busy", {31'd0, div_busy}, 32'd1);
      wait_done("restart_lat2", lat(8));
      exe_cmd = NOP;
      check("restart_quo", div_quotient, 32'h0B);
      check("restart_rem", div_remainder, 32'h01);
      tick();

      // rst_n mid-operation
      issue(`CMD_DIV, 32, 32'h3, 32'h0, 32'h1);
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      exe_cmd = NOP;
      tick();
      check("midrst_busy", {31'd0, div_busy}, 32'd1);
      check("midrst_quo",  div_quotient, 32'd0);
      check("midrst_rem",  div_remainder, 32'd0);
      check("midrst_exc",  {31'd0, exe_div_exception}, 32'd0);
      rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_divide_iter.md
Name: execute_divide_iter

Overview:
- Iterative divider in the execute stage; the inverse operation of the execute-stage multiplier.
- Handles DIV, IDIV and AAM for 8/16/32-bit operand sizes.
- Uses a restoring shift-subtract datapath with a small FSM and a busy/done handshake, so the execute stage can stall on it as it does on the multiplier.
- Reports divide-error (#DE) conditions to exception logic.

Parameters:
- None; command encodings `CMD_DIV, `CMD_IDIV, `CMD_AAM come from defines.v.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- exe_reset  in  1  pipeline flush; aborts any operation
- exe_cmd  in  7  current execute command
- exe_is_8bit  in  1  8-bit operand size
- exe_operand_16bit  in  1  16-bit operand size
- exe_operand_32bit  in  1  32-bit operand size
- src  in  32  divisor (AAM: imm8 in src[7:0])
- eax  in  32  dividend low part (AX for 8-bit, AX for 16-bit, EAX for 32-bit)
- edx  in  32  dividend high part (DX for 16-bit, EDX for 32-bit; unused for 8-bit/AAM)
- div_busy  out  1  high except in the DONE cycle
- div_quotient  out  32  quotient; valid in DONE; upper unused bits zero
- div_remainder  out  32  remainder; valid in DONE; upper unused bits zero
- exe_div_exception  out  1  #DE; valid in DONE

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low on rst_n.
  - Reset: state=IDLE, div_quotient=0, div_remainder=0, exe_div_exception=0, div_busy=1.
- Width and dividend:
  - N = 8 (exe_is_8bit or AAM), 16, or 32.
  - Dividend (2N bits): 8-bit {eax[15:0]}; 16-bit {edx[15:0],eax[15:0]}; 32-bit {edx,eax}.
  - AAM: dividend = eax[7:0] zero-extended; divisor = src[7:0]; always unsigned.
- States: IDLE, DIVIDE, FIXUP, DONE.
- IDLE:
  - Start when exe_cmd is DIV, IDIV or AAM.
  - On start, latch operand magnitudes: IDIV uses two's-complement absolute values; latch signs.
  - Divisor == 0: go to DONE with exception=1.
  - Unsigned DIV with dividend[2N-1:N] >= divisor: go to DONE with exception=1 (early overflow).
  - IDIV with |dividend high half| >= |divisor| (magnitude precheck): go to DONE with exception=1.
  - Otherwise: go to DIVIDE, iteration counter=N.
- DIVIDE:
  - One restoring step per cycle: partial remainder (N+1 bits) shifted left with the next dividend bit; subtract divisor if no borrow; quotient bit shifts in.
  - Counter decrements each step; go to FIXUP when it reaches 1 on the step.
- FIXUP:
  - IDIV quotient is negated if the signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Signed range check: a positive quotient > 2^(N-1)-1, or a negative one with magnitude > 2^(N-1), sets exception=1.
  - Results are masked to N bits. Next state DONE.
- DONE:
  - div_busy=0 for exactly one cycle; outputs are held stable.
  - Next state IDLE. Outputs keep their values until the next start.
  - A DIV/IDIV/AAM command still present in the cycle after DONE starts a new operation (same as the multiplier's restart rule); the pipeline advances on busy=0.
- AAM result placement: quotient → div_quotient[7:0] (AH), remainder → div_remainder[7:0] (AL).
- Latency (radix-2): start cycle + N DIVIDE + 1 FIXUP, so DONE on cycle N+2 after start. Exception at start: DONE on the next cycle.
- exe_reset:
  - In any state, next state is IDLE and exception is cleared; results are not updated.
  - exe_reset has priority over start in the same cycle.
- rst_n has priority over exe_reset.
- div_busy is high in IDLE; the pipeline ignores it when no divide command is present.

Optional Feature:
- Macro DIV_RADIX4_EN.
- Defined: two chained restoring steps per DIVIDE cycle, with the counter decremented by 2. Latency becomes N/2+2. Results and exceptions are identical.
- Undefined: radix-2 behaviour as above.

Test Plan:
- DIV 8-bit, eax=0x0064, src=0x07 → busy for 10 cycles, then DONE: quotient=0x0E, remainder=0x02, exception=0.
- IDIV 16-bit, edx=0xFFFF, eax=0xFF9C (-100), src=0x0007 → quotient=0xFFF2, remainder=0xFFFE, exception=0, DONE 18 cycles after start.
- DIV 32-bit, src=0 → DONE on the cycle after start, exception=1. Separately, DIV 32-bit with edx=5, src=5 → exception=1 with the same latency.
- IDIV 8-bit, eax=0x0080, src=0x01 → exception=1 (quotient 128 out of range). Then eax=0xFF80, src=0x01 → quotient=0x80, exception=0.
- AAM, eax=0x0000004F, src=0x0A → quotient=0x07, remainder=0x09.
- Reset handling:
  - DIV 32-bit with exe_reset asserted at iteration 5 → IDLE next cycle, no DONE pulse, outputs unchanged; a fresh DIV then completes correctly.
  - rst_n low mid-operation gives the reset values.
